reg_share_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 6 +
 rtl/rr_pick.sv | 20 ++
 rtl/reg_share_arbiter.sv | 99 +++++++++
 tb/tb_reg_share_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: arbiter state encoding and default sizing shared by the shared-register arbiter.
package arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker returning a one-hot winner starting the search at ptr.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic [NREQ-1:0]         excl,
    output logic [NREQ-1:0]         win,
    output logic                    valid
);
    logic [NREQ-1:0] w_eli;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_first;
    assign w_eli   = req & ~excl;
    // rotate so ptr sits at bit 0, take the lowest set bit, then rotate back
    assign w_rot   = NREQ'({2{w_eli}} >> ptr);
    assign w_first = w_rot & (~w_rot + 1'b1);
    assign win     = NREQ'(({2{w_first}} << ptr) >> NREQ);
    assign valid   = |w_eli;
endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin write arbiter for one shared register with registered grant/enable/data.
// Define ARB_LOCK_EN to enable the LOCKED ownership-hold state driven by the lock inputs.
module reg_share_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    reg_en,
    output logic [WIDTH-1:0]        reg_din,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);
    localparam int PW = $clog2(NREQ);
    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [NREQ-1:0]  r_gnt;
    logic             r_en;
    logic [WIDTH-1:0] r_din;
    logic [NREQ-1:0]  w_excl;
    logic [NREQ-1:0]  w_win;
    logic             w_valid;
    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0] w_win_data;
    assign w_excl = (r_state == GRANT) ? r_gnt : '0;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .excl  (w_excl),
        .win   (w_win),
        .valid (w_valid)
    );
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NREQ; k++)
            w_idx = w_win[k] ? PW'(k) : w_idx;
    end
    assign w_ptr_nxt  = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_win_data = wdata[w_idx*WIDTH +: WIDTH];
`ifdef ARB_LOCK_EN
    logic             w_own_req;
    logic             w_own_lock;
    logic [WIDTH-1:0] w_own_data;
    assign w_own_req  = req[r_owner];
    assign w_own_lock = lock[r_owner];
    assign w_own_data = wdata[r_owner*WIDTH +: WIDTH];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_en    <= 1'b0;
            r_din   <= '0;
        end else begin
`ifdef ARB_LOCK_EN
            // while locked the grant stays put and the owner's req/data pass through registered
            if (r_state != IDLE && w_own_lock) begin
                r_state <= LOCKED;
                r_en    <= w_own_req;
                r_din   <= w_own_data;
            end else if (r_state == LOCKED) begin
                r_state <= IDLE;
                r_gnt   <= '0;
                r_en    <= 1'b0;
            end else
`endif
            if (w_valid) begin
                r_state <= GRANT;
                r_gnt   <= w_win;
                r_en    <= 1'b1;
                r_din   <= w_win_data;
                r_owner <= w_idx;
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_state <= IDLE;
                r_gnt   <= '0;
                r_en    <= 1'b0;
            end
        end
    end
    assign gnt     = r_gnt;
    assign reg_en  = r_en;
    assign reg_din = r_din;
    assign owner   = r_owner;
    assign busy    = |r_gnt;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: table-driven directed checks of the shared-register arbiter plus lock/reset sequences.
module tb_reg_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic        reg_en;
    logic [3:0]  reg_din;
    logic [1:0]  owner;
    logic        busy;
    int checks   = 0;
    int failures = 0;
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [15:0] wdata;
        logic [3:0]  gnt;
        logic        en;
        logic [3:0]  din;
        logic [1:0]  owner;
    } vec_t;
    vec_t tbl[14];
    reg_share_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .reg_en  (reg_en),
        .reg_din (reg_din),
        .owner   (owner),
        .busy    (busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [3:0] eg, input logic ee,
                         input logic [3:0] ed, input logic [1:0] eo);
        checks++;
        if (gnt !== eg || reg_en !== ee || reg_din !== ed || owner !== eo || busy !== (|eg)) begin
            failures++;
            $display("FAIL %s: got gnt=%b en=%b din=%h owner=%0d busy=%b, want gnt=%b en=%b din=%h owner=%0d busy=%b",
                     nm, gnt, reg_en, reg_din, owner, busy, eg, ee, ed, eo, |eg);
        end
        checks++;
        if ($countones(gnt) > 1 || (reg_en && !busy)) begin
            failures++;
            $display("FAIL %s_onehot: got gnt=%b en=%b busy=%b, want at most one gnt bit and en implying busy",
                     nm, gnt, reg_en, busy);
        end
    endtask
    task automatic apply(input string nm, input logic [3:0] rq, input logic [3:0] lk,
                         input logic [15:0] wd, input logic [3:0] eg, input logic ee,
                         input logic [3:0] ed, input logic [1:0] eo);
        req   = rq;
        lock  = lk;
        wdata = wd;
        @(posedge clk);
        #1;
        check(nm, eg, ee, ed, eo);
    endtask
    initial begin
        // wdata slices: req0=3, req1=5, req2=A, req3=D
        tbl[0]  = '{4'b1111, 4'b0000, 16'hDA53, 4'b0001, 1'b1, 4'h3, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0000, 16'hDA53, 4'b0010, 1'b1, 4'h5, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0000, 16'hDA53, 4'b0100, 1'b1, 4'hA, 2'd2};
        tbl[3]  = '{4'b1111, 4'b0000, 16'hDA53, 4'b1000, 1'b1, 4'hD, 2'd3};
        tbl[4]  = '{4'b1111, 4'b0000, 16'hDA53, 4'b0001, 1'b1, 4'h3, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 16'hDA53, 4'b0000, 1'b0, 4'h3, 2'd0};
        tbl[6]  = '{4'b0100, 4'b0000, 16'hDA53, 4'b0100, 1'b1, 4'hA, 2'd2};
        tbl[7]  = '{4'b0100, 4'b0000, 16'hDA53, 4'b0000, 1'b0, 4'hA, 2'd2};
        tbl[8]  = '{4'b0100, 4'b0000, 16'hDA53, 4'b0100, 1'b1, 4'hA, 2'd2};
        tbl[9]  = '{4'b0000, 4'b0000, 16'hDA53, 4'b0000, 1'b0, 4'hA, 2'd2};
        tbl[10] = '{4'b1000, 4'b0000, 16'hDA53, 4'b1000, 1'b1, 4'hD, 2'd3};
        tbl[11] = '{4'b1010, 4'b0000, 16'hDA53, 4'b0010, 1'b1, 4'h5, 2'd1};
        tbl[12] = '{4'b1010, 4'b0000, 16'hDA53, 4'b1000, 1'b1, 4'hD, 2'd3};
        tbl[13] = '{4'b0000, 4'b0000, 16'hDA53, 4'b0000, 1'b0, 4'hD, 2'd3};
        rst   = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;
        wdata = 16'hDA53;
        @(posedge clk);
        #1;
        check("reset_hold", 4'b0000, 1'b0, 4'h0, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 14; i++)
            apply($sformatf("vec%0d", i), tbl[i].req, tbl[i].lock, tbl[i].wdata,
                  tbl[i].gnt, tbl[i].en, tbl[i].din, tbl[i].owner);
        // withdrawal: req[1] pulses between edges while requester 3 holds the grant
        apply("wd_grant3", 4'b1000, 4'b0000, 16'hDA53, 4'b1000, 1'b1, 4'hD, 2'd3);
        req = 4'b0010;
        #5;
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("wd_no_gnt", 4'b0000, 1'b0, 4'hD, 2'd3);
        apply("wd_stay_idle", 4'b0000, 4'b0000, 16'hDA53, 4'b0000, 1'b0, 4'hD, 2'd3);
        apply("lk_grant2", 4'b0100, 4'b0000, 16'hDA53, 4'b0100, 1'b1, 4'hA, 2'd2);
`ifdef ARB_LOCK_EN
        apply("lk_hold1", 4'b0101, 4'b0100, 16'hD753, 4'b0100, 1'b1, 4'h7, 2'd2);
        apply("lk_hold2", 4'b0001, 4'b0100, 16'hD153, 4'b0100, 1'b0, 4'h1, 2'd2);
        apply("lk_hold3", 4'b0101, 4'b0100, 16'hD953, 4'b0100, 1'b1, 4'h9, 2'd2);
        apply("lk_hold4", 4'b0101, 4'b0100, 16'hDA53, 4'b0100, 1'b1, 4'hA, 2'd2);
        apply("lk_hold5", 4'b0001, 4'b0100, 16'hDA53, 4'b0100, 1'b0, 4'hA, 2'd2);
        apply("lk_exit", 4'b0001, 4'b0000, 16'hDA53, 4'b0000, 1'b0, 4'hA, 2'd2);
        apply("lk_next0", 4'b0001, 4'b0000, 16'hDA53, 4'b0001, 1'b1, 4'h3, 2'd0);
        apply("lk_grant1", 4'b0010, 4'b0010, 16'hDA53, 4'b0010, 1'b1, 4'h5, 2'd1);
        apply("lk_locked1", 4'b0010, 4'b0010, 16'hDA53, 4'b0010, 1'b1, 4'h5, 2'd1);
`else
        apply("nolk_ignored", 4'b0101, 4'b0100, 16'hD753, 4'b0001, 1'b1, 4'h3, 2'd0);
        apply("nolk_next2", 4'b0101, 4'b0100, 16'hD753, 4'b0100, 1'b1, 4'h7, 2'd2);
`endif
        // asynchronous reset in the middle of a held grant
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 4'b0000, 1'b0, 4'h0, 2'd0);
        @(posedge clk);
        #1;
        check("rst_held", 4'b0000, 1'b0, 4'h0, 2'd0);
        rst = 1'b0;
        apply("post_rst0", 4'b1111, 4'b0000, 16'hDA53, 4'b0001, 1'b1, 4'h3, 2'd0);
        apply("post_rst1", 4'b1111, 4'b0000, 16'hDA53, 4'b0010, 1'b1, 4'h5, 2'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
